// File: rtl/lcd_frame_scheduler_if.sv
// Frame scheduler handshake bundle.
// master = scheduler side, slave = LCD datapath / top side.
`timescale 1ns/1ps
interface lcd_frame_scheduler_if;
  logic        init_done;
  logic        frame_ack;
  logic        pause;
  logic        frame_req;
  logic [2:0]  frame_color_id;
  logic [2:0]  test_color_id;
  logic        display_active;
  logic [15:0] frame_cnt;
  logic        fault;

  modport master (
    input  init_done,
    input  frame_ack,
    input  pause,
    output frame_req,
    output frame_color_id,
    output test_color_id,
    output display_active,
    output frame_cnt,
    output fault
  );

  modport slave (
    output init_done,
    output frame_ack,
    output pause,
    input  frame_req,
    input  frame_color_id,
    input  test_color_id,
    input  display_active,
    input  frame_cnt,
    input  fault
  );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// LCD frame scheduler: colour rotation, frame req/ack, gap, watchdog.
// Optional FRAME_SCHED_PAUSE_EN: pause holds rotation at gap expiry.
`timescale 1ns/1ps
module lcd_frame_scheduler #(
  parameter int NUM_COLORS     = 8,
  parameter int HOLD_FRAMES    = 4,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk_25MHz,
  input  logic                 rst,
  lcd_frame_scheduler_if.master io
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [2:0]    COLOR_LAST = 3'(NUM_COLORS - 1);

  localparam logic [1:0] S_WAIT_INIT = 2'd0;
  localparam logic [1:0] S_REQ       = 2'd1;
  localparam logic [1:0] S_GAP       = 2'd2;
  localparam logic [1:0] S_FAULT     = 2'd3;

  logic [1:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_color;
  logic [15:0]   r_cnt;

  logic w_gap_done;
  logic w_tmo_done;
  logic w_hold_gap;

  assign w_gap_done = (r_gap == GAP_LAST);
  assign w_tmo_done = (r_tmo == TMO_LAST);

`ifdef FRAME_SCHED_PAUSE_EN
  assign w_hold_gap = io.pause;
`else
  logic w_unused_pause;
  assign w_unused_pause = io.pause;
  assign w_hold_gap     = 1'b0;
`endif

  // Frame sequencing state, counters and colour rotation
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      r_state <= S_WAIT_INIT;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_hold  <= '0;
      r_color <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_WAIT_INIT: begin
          if (io.init_done) begin
            r_state <= S_REQ;
            r_tmo   <= '0;
          end
        end
        S_REQ: begin
          if (io.frame_ack) begin
            r_state <= S_GAP;
            r_gap   <= '0;
            r_cnt   <= r_cnt + 16'd1;
            if (r_hold == HOLD_LAST) begin
              r_hold  <= '0;
              r_color <= (r_color == COLOR_LAST) ?
                         3'd0 : r_color + 3'd1;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end else if (w_tmo_done) begin
            r_state <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_GAP: begin
          if (!w_gap_done) begin
            r_gap <= r_gap + GW'(1);
          end else if (!w_hold_gap) begin
            r_tmo   <= '0;
            r_state <= io.init_done ? S_REQ : S_WAIT_INIT;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: r_state <= S_WAIT_INIT;
      endcase
    end
  end

  assign io.frame_req      = (r_state == S_REQ);
  assign io.display_active = (r_state == S_REQ) ||
                             (r_state == S_GAP);
  assign io.fault          = (r_state == S_FAULT);
  assign io.frame_color_id = r_color;
  assign io.test_color_id  = r_color;
  assign io.frame_cnt      = r_cnt;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: vector table, directed corners,
// and random traffic against an event-level reference model.
`timescale 1ns/1ps
module tb_lcd_frame_scheduler;

  localparam int NC = 3;
  localparam int HF = 2;
  localparam int GC = 4;
  localparam int TC = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_frame_scheduler_if bus();

  lcd_frame_scheduler #(
    .NUM_COLORS(NC), .HOLD_FRAMES(HF),
    .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_25MHz(clk),
    .rst(rst),
    .io(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        init;
    logic        ack;
    logic        req;
    logic [2:0]  col;
    logic [15:0] cnt;
    logic        act;
    logic        flt;
  } vec_t;

  vec_t tbl[11];

  bit m_req;
  bit m_flt;
  int m_gap;
  int m_n;
  int m_age;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.init_done = 1'b0;
    bus.frame_ack = 1'b0;
    bus.pause     = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_req(output int k);
    k = 0;
    while (!bus.frame_req && k < 200) begin
      step();
      k++;
    end
    if (!bus.frame_req) chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int hold);
    int k;
    wait_req(k);
    repeat (hold) step();
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
  endtask

  // Event-level model: acks counted, colour derived from the count.
  task automatic m_tick(input bit r, input bit init,
                        input bit ack, input bit pz);
    bit pen;
`ifdef FRAME_SCHED_PAUSE_EN
    pen = pz;
`else
    pen = 1'b0;
    if (pz) pen = 1'b0;
`endif
    if (r) begin
      m_req = 0; m_flt = 0; m_gap = 0; m_n = 0; m_age = 0;
    end else if (m_flt) begin
      m_flt = 1;
    end else if (m_req) begin
      if (ack) begin
        m_n++; m_req = 0; m_gap = GC;
      end else if (m_age == TC - 1) begin
        m_flt = 1; m_req = 0;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      if (!(m_gap == 1 && pen)) begin
        m_gap--;
        if (m_gap == 0 && init) begin
          m_req = 1; m_age = 0;
        end
      end
    end else if (init) begin
      m_req = 1; m_age = 0;
    end
  endtask

  initial begin
    int k;
    int cseq[8];
    bus.init_done = 1'b0;
    bus.frame_ack = 1'b0;
    bus.pause     = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'd2, 1'b1, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst           = tbl[i].rst;
      bus.init_done = tbl[i].init;
      bus.frame_ack = tbl[i].ack;
      step();
      chk($sformatf("vec%0d_req", i),
          32'(bus.frame_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_col", i),
          32'(bus.test_color_id), 32'(tbl[i].col));
      chk($sformatf("vec%0d_fcol", i),
          32'(bus.frame_color_id), 32'(tbl[i].col));
      chk($sformatf("vec%0d_cnt", i),
          32'(bus.frame_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_act", i),
          32'(bus.display_active), 32'(tbl[i].act));
      chk($sformatf("vec%0d_flt", i),
          32'(bus.fault), 32'(tbl[i].flt));
    end
    bus.frame_ack = 1'b0;

    // Rotation: 8 frames acked after 10 cycles each
    cseq = '{0, 0, 1, 1, 2, 2, 0, 0};
    do_reset();
    bus.init_done = 1'b1;
    for (int f = 0; f < 8; f++) begin
      wait_req(k);
      if (f == 0) chk("rot_startup_lat", 32'(k), 32'd1);
      else chk($sformatf("rot_gap%0d", f), 32'(k + 1), 32'd5);
      chk($sformatf("rot_col%0d", f),
          32'(bus.frame_color_id), 32'(cseq[f]));
      repeat (9) step();
      bus.frame_ack = 1'b1;
      step();
      bus.frame_ack = 1'b0;
    end
    chk("rot_cnt", 32'(bus.frame_cnt), 32'd8);

    // Watchdog expiry, sticky fault, reset recovery
    do_reset();
    bus.init_done = 1'b1;
    step();
    chk("wd_rise", 32'(bus.frame_req), 32'd1);
    repeat (49) step();
    chk("wd_49_flt", 32'(bus.fault), 32'd0);
    chk("wd_49_req", 32'(bus.frame_req), 32'd1);
    step();
    chk("wd_50_flt", 32'(bus.fault), 32'd1);
    chk("wd_50_req", 32'(bus.frame_req), 32'd0);
    chk("wd_50_act", 32'(bus.display_active), 32'd0);
    bus.frame_ack = 1'b1;
    repeat (5) step();
    bus.frame_ack = 1'b0;
    chk("wd_sticky", 32'(bus.fault), 32'd1);
    chk("wd_sticky_cnt", 32'(bus.frame_cnt), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wd_rst_flt", 32'(bus.fault), 32'd0);
    chk("wd_rst_req", 32'(bus.frame_req), 32'd0);
    step();
    chk("wd_rerise", 32'(bus.frame_req), 32'd1);
    repeat (49) step();
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    chk("wd_ackwin_flt", 32'(bus.fault), 32'd0);
    chk("wd_ackwin_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("wd_ackwin_act", 32'(bus.display_active), 32'd1);

    // Init drop during gap after colour 1's first frame
    do_reset();
    bus.init_done = 1'b1;
    run_frame(3);
    run_frame(3);
    run_frame(3);
    bus.init_done = 1'b0;
    chk("id_col_gap", 32'(bus.test_color_id), 32'd1);
    repeat (4) step();
    chk("id_wait_act", 32'(bus.display_active), 32'd0);
    repeat (5) step();
    chk("id_wait_req", 32'(bus.frame_req), 32'd0);
    chk("id_wait_col", 32'(bus.test_color_id), 32'd1);
    bus.init_done = 1'b1;
    step();
    chk("id_re_req", 32'(bus.frame_req), 32'd1);
    chk("id_re_col", 32'(bus.frame_color_id), 32'd1);
    step();
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    chk("id_adv_col", 32'(bus.test_color_id), 32'd2);
    chk("id_adv_cnt", 32'(bus.frame_cnt), 32'd4);

    // Spurious ack in gap, then reset mid-frame with a late ack
    do_reset();
    bus.init_done = 1'b1;
    run_frame(2);
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    chk("sp_cnt", 32'(bus.frame_cnt), 32'd1);
    wait_req(k);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_req", 32'(bus.frame_req), 32'd0);
    chk("mr_cnt", 32'(bus.frame_cnt), 32'd0);
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    chk("mr_late_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("mr_late_req", 32'(bus.frame_req), 32'd1);

    // Pause across gap expiry
    do_reset();
    bus.init_done = 1'b1;
    run_frame(2);
    bus.pause = 1'b1;
    repeat (4) step();
`ifdef FRAME_SCHED_PAUSE_EN
    chk("pz_hold4", 32'(bus.frame_req), 32'd0);
    repeat (16) step();
    chk("pz_hold20", 32'(bus.frame_req), 32'd0);
    chk("pz_act", 32'(bus.display_active), 32'd1);
    bus.pause = 1'b0;
    step();
    chk("pz_release", 32'(bus.frame_req), 32'd1);
`else
    chk("pz_ignored", 32'(bus.frame_req), 32'd1);
`endif
    bus.pause = 1'b0;

    // Random traffic against the reference model
    rst = 1'b1;
    bus.frame_ack = 1'b0;
    m_tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bit r, in, ak, pz;
      r  = ($urandom_range(0, 299) == 0);
      in = ($urandom_range(0, 9) != 0);
      pz = ($urandom_range(0, 7) == 0);
      if (m_req && m_age >= 40) ak = 1'b1;
      else if (m_req) ak = ($urandom_range(0, 5) == 0);
      else ak = ($urandom_range(0, 9) == 0);
      rst           = r;
      bus.init_done = in;
      bus.frame_ack = ak;
      bus.pause     = pz;
      m_tick(r, in, ak, pz);
      step();
      chk("rnd_req", 32'(bus.frame_req), 32'(m_req));
      chk("rnd_flt", 32'(bus.fault), 32'(m_flt));
      chk("rnd_act", 32'(bus.display_active),
          32'(m_req || m_gap > 0));
      chk("rnd_cnt", 32'(bus.frame_cnt), 32'(m_n % 65536));
      chk("rnd_col", 32'(bus.test_color_id), 32'((m_n / HF) % NC));
      chk("rnd_fcol", 32'(bus.frame_color_id),
          32'((m_n / HF) % NC));
    end
    rst = 1'b0;
    bus.frame_ack = 1'b0;
    bus.pause = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
